// File: rtl/equation_pipe_pkg.sv
// Shared widths, operand/product types and the saturation ceiling for the
// E = A*B + B*C + A*C pipeline.
package equation_pipe_pkg;

  localparam int IN_W  = 8;
  localparam int OUT_W = 2 * IN_W;

  typedef logic [IN_W-1:0]  operand_t;
  typedef logic [OUT_W-1:0] prod_t;

  // Stage-2 pair sum carries one extra bit so s1+s2 never loses a carry.
  typedef logic [OUT_W:0]   pair_sum_t;

  localparam prod_t E_MAX = 16'hFFFF;

endpackage : equation_pipe_pkg

// File: rtl/equation_pipe_if.sv
// Operand/result bundle of equation_pipe. There is no handshake: operands are
// consumed on every rising clk edge and every output is a plain registered value.
interface equation_pipe_if;
  import equation_pipe_pkg::*;

  operand_t A;
  operand_t B;
  operand_t C;
  prod_t    s1;
  prod_t    s2;
  prod_t    s3;
  prod_t    E;

  modport master (
    output A, B, C,
    input  s1, s2, s3, E
  );

  modport slave (
    input  A, B, C,
    output s1, s2, s3, E
  );

endinterface : equation_pipe_if

// File: rtl/equation_pipe_mul.sv
// eq_mul: combinational unsigned IN_W x IN_W -> OUT_W multiplier. The product
// width equals the sum of the operand widths, so no bits are ever dropped.
module eq_mul
  import equation_pipe_pkg::*;
(
  input  operand_t a,
  input  operand_t b,
  output prod_t    p
);

  assign p = prod_t'(a) * prod_t'(b);

endmodule : eq_mul

// File: rtl/equation_pipe.sv
// equation_pipe: 3-stage evaluator of E = A*B + B*C + A*C. Defining
// EQUATION_PIPE_SAT_EN clamps E at E_MAX instead of wrapping modulo 2^16.
module equation_pipe
  import equation_pipe_pkg::*;
(
  input logic            clk,
  input logic            rst,
  equation_pipe_if.slave bus
);

  prod_t     ab, bc, ac;
  prod_t     s1_q, s2_q, s3_q;
  pair_sum_t p12_q;
  prod_t     p3_q;
  prod_t     e_q;
  prod_t     e_next;

  eq_mul u_mul_ab (.a(bus.A), .b(bus.B), .p(ab));
  eq_mul u_mul_bc (.a(bus.B), .b(bus.C), .p(bc));
  eq_mul u_mul_ac (.a(bus.A), .b(bus.C), .p(ac));

`ifdef EQUATION_PIPE_SAT_EN
  // Three full-scale products can reach ~3*2^16, so the final sum needs two guard bits.
  logic [OUT_W+1:0] sum3;

  always_comb begin
    sum3   = {1'b0, p12_q} + {2'b00, p3_q};
    e_next = (sum3 > {2'b00, E_MAX}) ? E_MAX : sum3[OUT_W-1:0];
  end
`else
  always_comb begin
    e_next = prod_t'(p12_q + {1'b0, p3_q});
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q  <= '0;
      s2_q  <= '0;
      s3_q  <= '0;
      p12_q <= '0;
      p3_q  <= '0;
      e_q   <= '0;
    end else begin
      s1_q  <= ab;
      s2_q  <= bc;
      s3_q  <= ac;
      p12_q <= {1'b0, s1_q} + {1'b0, s2_q};
      p3_q  <= s3_q;
      e_q   <= e_next;
    end
  end

  assign bus.s1 = s1_q;
  assign bus.s2 = s2_q;
  assign bus.s3 = s3_q;
  assign bus.E  = e_q;

endmodule : equation_pipe

// File: tb/tb_equation_pipe.sv
// Self-checking bench for equation_pipe: directed vectors followed by random
// triples with sporadic resets, compared against a per-edge arithmetic model.
module tb_equation_pipe;

  logic clk;
  logic rst;

  equation_pipe_if bus ();

  equation_pipe dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];   // model result of the triple sampled at each edge
  bit          rst_q[$];   // reset level sampled at each edge
  int          n_assert;
  int          n_fail;

  function automatic logic [15:0] model_e(input int unsigned a, b, c);
    int unsigned sum;
    sum = a * b + b * c + a * c;
`ifdef EQUATION_PIPE_SAT_EN
    return (sum > 65535) ? 16'hFFFF : 16'(sum);
`else
    return 16'(sum % 65536);
`endif
  endfunction

  // E after the latest edge reflects the triple two edges back, unless a reset
  // landed anywhere in that three-edge window.
  function automatic logic [15:0] expected_e();
    int k;
    k = rst_q.size() - 1;
    if (k < 2) return 16'd0;
    if (rst_q[k] || rst_q[k-1] || rst_q[k-2]) return 16'd0;
    return exp_q[k-2];
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input int unsigned a, b, c, input bit r);
    logic [15:0] e1, e2, e3;
    bus.A = 8'(a);
    bus.B = 8'(b);
    bus.C = 8'(c);
    rst   = r;
    @(posedge clk);
    rst_q.push_back(r);
    exp_q.push_back(r ? 16'd0 : model_e(a, b, c));
    e1 = r ? 16'd0 : 16'(a * b);
    e2 = r ? 16'd0 : 16'(b * c);
    e3 = r ? 16'd0 : 16'(a * c);
    #1;
    check("s1", bus.s1, e1);
    check("s2", bus.s2, e2);
    check("s3", bus.s3, e3);
    check("E",  bus.E,  expected_e());
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst      = 1'b1;
    bus.A    = '0;
    bus.B    = '0;
    bus.C    = '0;

    // Reset held two edges with nonzero operands.
    step(17, 33, 99, 1'b1);
    step(17, 33, 99, 1'b1);
    check("rst_s1", bus.s1, 16'd0);
    check("rst_E",  bus.E,  16'd0);

    // Directed example: 21,52,90.
    step(21, 52, 90, 1'b0);
    check("ex_s1", bus.s1, 16'd1092);
    check("ex_s2", bus.s2, 16'd4680);
    check("ex_s3", bus.s3, 16'd1890);
    step(0, 0, 0, 1'b0);
    step(0, 0, 0, 1'b0);
    check("ex_E", bus.E, 16'd7662);

    // Back-to-back triples, no bubbles.
    step(1, 1, 1, 1'b0);
    step(0, 0, 0, 1'b0);
    step(2, 1, 1, 1'b0);
    check("b2b_E0", bus.E, 16'd3);
    step(0, 0, 0, 1'b0);
    check("b2b_E1", bus.E, 16'd0);
    step(0, 0, 0, 1'b0);
    check("b2b_E2", bus.E, 16'd5);

    // All-ones operands: overflow path.
    step(255, 255, 255, 1'b0);
    check("max_s1", bus.s1, 16'd65025);
    step(0, 0, 0, 1'b0);
    step(0, 0, 0, 1'b0);
`ifdef EQUATION_PIPE_SAT_EN
    check("max_E", bus.E, 16'd65535);
`else
    check("max_E", bus.E, 16'd64003);
`endif

    // Single nonzero term.
    step(255, 0, 255, 1'b0);
    check("one_s3", bus.s3, 16'd65025);
    step(0, 0, 0, 1'b0);
    step(0, 0, 0, 1'b0);
    check("one_E", bus.E, 16'd65025);

    // Mid-flight reset flushes three in-flight triples.
    step(200, 100, 50, 1'b0);
    step(150, 250, 10, 1'b0);
    step(99, 77, 123, 1'b0);
    step(99, 77, 123, 1'b1);
    check("flush_s1", bus.s1, 16'd0);
    check("flush_E0", bus.E,  16'd0);
    step(3, 4, 5, 1'b0);
    check("flush_E1", bus.E, 16'd0);
    step(3, 4, 5, 1'b0);
    check("flush_E2", bus.E, 16'd0);
    step(3, 4, 5, 1'b0);
    check("flush_E3", bus.E, 16'd47);

    // Random triples with occasional resets.
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
           ($urandom_range(0, 24) == 0));
    end

    // Drain so the last random triples reach E.
    step(0, 0, 0, 1'b0);
    step(0, 0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_equation_pipe
